des_key_schedule: RTL and testbench

- Sequential DES key scheduler.
- Accepts a 64-bit key with valid/ready, applies Permuted Choice 1, then emits the 16 round subkeys K1..K16 (48 bits each) one per handshake.
- Supports encrypt order (K1 to K16, left rotations) and decrypt order (K16 to K1, right rotations).
- Feeds the DES round datapath; checks per-byte odd key parity.

---
 rtl/des_key_schedule.sv | 145 ++++++++++++++
 tb/tb_des_key_schedule.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES round-subkey generator (PC1, C/D rotation, PC2)
module des_key_schedule #(
  parameter bit PARITY_CHECK = 1'b1,
  parameter bit FIXED_ORDER  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [1:48] subkey,
  output logic [3:0]  subkey_round,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        subkey_last,
  output logic        parity_err
);

  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic        mode;
  logic [1:28] c, d;
  logic [4:0]  count;

  function automatic logic [1:56] apply_pc1(input logic [1:64] k);
    logic [1:56] r;
    for (int i = 0; i < 56; i++) r[i+1] = k[PC1[i]];
    return r;
  endfunction

  function automatic logic [1:48] apply_pc2(input logic [1:56] cd);
    logic [1:48] r;
    for (int i = 0; i < 48; i++) r[i+1] = cd[PC2[i]];
    return r;
  endfunction

  // Schedule entry S[idx] is 1 at rounds 1, 2, 9 and 16, otherwise 2.
  function automatic logic shift_two(input logic [4:0] idx);
    return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
    return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
    return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  logic [1:56] pc1_key;
  logic        key_fire, sub_fire, mode_in, key_par_bad, step_two;
  logic [4:0]  round_dec, round_enc;

  always_comb begin
    pc1_key     = apply_pc1(key_in);
    key_par_bad = 1'b0;
    for (int b = 0; b < 8; b++)
      if (!(^key_in[8*b+1 +: 8])) key_par_bad = 1'b1;
  end

  assign key_fire = key_valid && key_ready;
  assign sub_fire = subkey_valid && subkey_ready;
  assign mode_in  = decrypt && !FIXED_ORDER;
  // Encrypt steps forward through S; decrypt walks it backwards (S[17-count]).
  assign step_two = mode ? shift_two(5'd17 - count) : shift_two(count + 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      c          <= '0;
      d          <= '0;
      count      <= '0;
      parity_err <= 1'b0;
    end else begin
      state <= state_next;
      if (key_fire) begin
        mode       <= mode_in;
        count      <= 5'd1;
        parity_err <= PARITY_CHECK && key_par_bad;
        if (mode_in) begin
          c <= pc1_key[1:28];
          d <= pc1_key[29:56];
        end else begin
          c <= rotl(pc1_key[1:28], 1'b0);
          d <= rotl(pc1_key[29:56], 1'b0);
        end
      end else if (sub_fire && count != 5'd16) begin
        count <= count + 5'd1;
        c     <= mode ? rotr(c, step_two) : rotl(c, step_two);
        d     <= mode ? rotr(d, step_two) : rotl(d, step_two);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (key_fire) state_next = RUN;
      RUN:  if (sub_fire && count == 5'd16) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign round_dec = 5'd16 - count;
  assign round_enc = count - 5'd1;

  always_comb begin
    key_ready    = (state == IDLE);
    subkey_valid = (state == RUN);
    subkey       = '0;
    subkey_round = '0;
    subkey_last  = 1'b0;
    if (state == RUN) begin
      subkey       = apply_pc2({c, d});
      subkey_round = mode ? round_dec[3:0] : round_enc[3:0];
      subkey_last  = (count == 5'd16);
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - randomized self-checking bench against a table-driven DES key schedule model
module tb_des_key_schedule;

  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h123457799BBCDFF1;

  logic clk = 1'b0, rst = 1'b1, decrypt = 1'b0, key_valid = 1'b0, subkey_ready = 1'b0;
  logic [63:0] key_in = '0;
  logic key_ready, subkey_valid, subkey_last, parity_err;
  logic [47:0] subkey;
  logic [3:0]  subkey_round;
  logic key_ready_fx, subkey_valid_fx, subkey_last_fx, parity_err_fx;
  logic [47:0] subkey_fx;
  logic [3:0]  subkey_round_fx;
  logic key_ready_np, subkey_valid_np, subkey_last_np, parity_err_np;
  logic [47:0] subkey_np;
  logic [3:0]  subkey_round_np;

  always #5 clk = ~clk;

  des_key_schedule dut (.clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt), .key_valid(key_valid),
    .key_ready(key_ready), .subkey(subkey), .subkey_round(subkey_round), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .subkey_last(subkey_last), .parity_err(parity_err));
  des_key_schedule #(.FIXED_ORDER(1'b1)) dut_fx (.clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt),
    .key_valid(key_valid), .key_ready(key_ready_fx), .subkey(subkey_fx), .subkey_round(subkey_round_fx),
    .subkey_valid(subkey_valid_fx), .subkey_ready(subkey_ready), .subkey_last(subkey_last_fx),
    .parity_err(parity_err_fx));
  des_key_schedule #(.PARITY_CHECK(1'b0)) dut_np (.clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt),
    .key_valid(key_valid), .key_ready(key_ready_np), .subkey(subkey_np), .subkey_round(subkey_round_np),
    .subkey_valid(subkey_valid_np), .subkey_ready(subkey_ready), .subkey_last(subkey_last_np),
    .parity_err(parity_err_np));

  int n_cmp = 0, n_err = 0;

  logic [47:0] exp_k [16];
  logic        exp_par;
  logic [47:0] obs_k[$], obs_fx[$];
  logic [3:0]  obs_r[$];
  logic        obs_l[$];
  int  stall_bad, stall_cycles;
  bit  timed_out, first_valid, first_par, first_par_np;

  // Reference: FIPS 46-3 key schedule on plain integers, bit p (1 = MSB) of a value is at index W-p.
  task automatic model(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      c  = (c << SHIFTS[r]) | (c >> (28 - SHIFTS[r]));
      d  = (d << SHIFTS[r]) | (d >> (28 - SHIFTS[r]));
      cd = {c, d};
      for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2_T[j]];
      exp_k[r] = k;
    end
    exp_par = 1'b0;
    for (int b = 0; b < 8; b++)
      if ($countones(key[8*b +: 8]) % 2 == 0) exp_par = 1'b1;
  endtask

  task automatic load_key(input logic [63:0] key, input logic dec);
    @(negedge clk);
    for (int i = 0; i < 40 && !key_ready; i++) @(negedge clk);
    key_in = key;
    decrypt = dec;
    key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  task automatic collect(input int ready_pct, input int stop_after);
    bit prev_stall = 1'b0;
    logic [47:0] pk = '0;
    logic [3:0]  pr = '0;
    obs_k.delete(); obs_fx.delete(); obs_r.delete(); obs_l.delete();
    stall_bad = 0; stall_cycles = 0; timed_out = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        first_valid = subkey_valid;
        first_par = parity_err;
        first_par_np = parity_err_np;
      end
      if (prev_stall && (subkey !== pk || subkey_round !== pr)) stall_bad++;
      subkey_ready = ($urandom_range(99) < ready_pct);
      prev_stall = subkey_valid && !subkey_ready;
      pk = subkey;
      pr = subkey_round;
      if (prev_stall) stall_cycles++;
      if (subkey_valid && subkey_ready) begin
        obs_k.push_back(subkey);
        obs_fx.push_back(subkey_fx);
        obs_r.push_back(subkey_round);
        obs_l.push_back(subkey_last);
        if (obs_k.size() == stop_after) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({key_ready, subkey_valid, subkey_last, parity_err} !== 4'b1000 || subkey !== 48'h0 || subkey_round !== 4'h0) begin
      n_err++;
      $display("FAIL reset: rdy/vld/last/par=%b subkey=%h round=%0d, required 1000/0/0",
               {key_ready, subkey_valid, subkey_last, parity_err}, subkey, subkey_round);
    end
  endtask

  task automatic test_encrypt;
    model(KEY_STD);
    load_key(KEY_STD, 1'b0);
    collect(100, 16);
    n_cmp++;
    if (timed_out || !first_valid) begin
      n_err++; $display("FAIL enc_latency: timed_out=%0b first_valid=%0b, required 0/1", timed_out, first_valid);
    end
    n_cmp++;
    if (!timed_out && (obs_k[0] !== 48'h1B02EFFC7072 || obs_k[15] !== 48'hCB3D8B0E17F5)) begin
      n_err++; $display("FAIL enc_known: K1=%h K16=%h, required 1b02effc7072/cb3d8b0e17f5", obs_k[0], obs_k[15]);
    end
    for (int i = 0; i < obs_k.size(); i++) begin
      n_cmp++;
      if (obs_k[i] !== exp_k[i] || obs_r[i] !== 4'(i) || obs_l[i] !== (i == 15)) begin
        n_err++;
        $display("FAIL enc_seq[%0d]: key=%h round=%0d last=%0b, required %h/%0d/%0b",
                 i, obs_k[i], obs_r[i], obs_l[i], exp_k[i], i, i == 15);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (key_ready !== 1'b1 || subkey_valid !== 1'b0 || parity_err !== 1'b0) begin
      n_err++; $display("FAIL enc_end: rdy=%b vld=%b par=%b, required 1/0/0", key_ready, subkey_valid, parity_err);
    end
  endtask

  task automatic test_decrypt;
    model(KEY_STD);
    load_key(KEY_STD, 1'b1);
    collect(100, 16);
    n_cmp++;
    if (timed_out || obs_k[0] !== 48'hCB3D8B0E17F5 || obs_r[0] !== 4'd15) begin
      n_err++; $display("FAIL dec_first: timed_out=%0b key=%h round=%0d, required cb3d8b0e17f5/15",
                        timed_out, obs_k[0], obs_r[0]);
    end
    for (int i = 0; i < obs_k.size(); i++) begin
      n_cmp++;
      if (obs_k[i] !== exp_k[15-i] || obs_r[i] !== 4'(15 - i) || obs_l[i] !== (i == 15)) begin
        n_err++;
        $display("FAIL dec_seq[%0d]: key=%h round=%0d last=%0b, required %h/%0d/%0b",
                 i, obs_k[i], obs_r[i], obs_l[i], exp_k[15-i], 15 - i, i == 15);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fixed_order;
    logic [63:0] key;
    key = {$urandom, $urandom};
    model(key);
    load_key(key, 1'b1);
    collect(100, 16);
    n_cmp++;
    if (timed_out || obs_fx.size() != 16) begin
      n_err++; $display("FAIL fixed_count: got %0d subkeys, required 16", obs_fx.size());
    end
    for (int i = 0; i < obs_fx.size(); i++) begin
      n_cmp++;
      if (obs_fx[i] !== exp_k[i] || obs_k[i] !== exp_k[15-i]) begin
        n_err++; $display("FAIL fixed_seq[%0d]: fixed=%h dec=%h, required %h/%h",
                          i, obs_fx[i], obs_k[i], exp_k[i], exp_k[15-i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    logic [63:0] key;
    logic dec;
    for (int t = 0; t < 3; t++) begin
      key = {$urandom, $urandom};
      dec = 1'($urandom_range(1));
      model(key);
      load_key(key, dec);
      collect(50, 16);
      n_cmp++;
      if (timed_out || obs_k.size() != 16 || stall_bad != 0 || stall_cycles == 0) begin
        n_err++; $display("FAIL stall_ctl[%0d]: handshakes=%0d unstable=%0d stalls=%0d, required 16/0/>0",
                          t, obs_k.size(), stall_bad, stall_cycles);
      end
      for (int i = 0; i < obs_k.size(); i++) begin
        n_cmp++;
        if (obs_k[i] !== exp_k[dec ? 15 - i : i]) begin
          n_err++; $display("FAIL stall_seq[%0d][%0d]: key=%h, required %h", t, i, obs_k[i], exp_k[dec ? 15 - i : i]);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
        n_err++; $display("FAIL stall_end[%0d]: vld=%b rdy=%b, required 0/1", t, subkey_valid, key_ready);
      end
    end
  endtask

  task automatic test_parity;
    model(KEY_BAD);
    load_key(KEY_BAD, 1'b0);
    collect(100, 16);
    n_cmp++;
    if (first_par !== 1'b1 || first_par_np !== 1'b0 || exp_par !== 1'b1) begin
      n_err++; $display("FAIL parity_bad: par=%b par_off=%b, required 1/0", first_par, first_par_np);
    end
    n_cmp++;
    if (timed_out || obs_k[0] !== exp_k[0] || obs_k[15] !== exp_k[15]) begin
      n_err++; $display("FAIL parity_keys: K1=%h K16=%h, required %h/%h", obs_k[0], obs_k[15], exp_k[0], exp_k[15]);
    end
    @(negedge clk);
    n_cmp++;
    if (parity_err !== 1'b1) begin
      n_err++; $display("FAIL parity_hold: par=%b, required 1", parity_err);
    end
    load_key(KEY_STD, 1'b0);
    collect(100, 16);
    n_cmp++;
    if (first_par !== 1'b0) begin
      n_err++; $display("FAIL parity_good: par=%b, required 0", first_par);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic [63:0] key;
    int v_seen;
    model(KEY_STD);
    load_key(KEY_STD, 1'b0);
    collect(100, 5);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    subkey_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (subkey_valid !== 1'b0 || key_ready !== 1'b1 || subkey !== 48'h0 || subkey_round !== 4'h0 || parity_err !== 1'b0) begin
      n_err++; $display("FAIL abort_state: vld=%b rdy=%b subkey=%h round=%0d par=%b, required 0/1/0/0/0",
                        subkey_valid, key_ready, subkey, subkey_round, parity_err);
    end
    v_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (subkey_valid) v_seen++;
    end
    n_cmp++;
    if (v_seen != 0) begin
      n_err++; $display("FAIL abort_quiet: %0d valid cycles after reset, required 0", v_seen);
    end
    key = {$urandom, $urandom};
    model(key);
    load_key(key, 1'b0);
    collect(100, 16);
    n_cmp++;
    if (timed_out || obs_k[0] !== exp_k[0] || obs_r[0] !== 4'd0) begin
      n_err++; $display("FAIL abort_fresh: K1=%h round=%0d, required %h/0", obs_k[0], obs_r[0], exp_k[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_key_ignored;
    logic [63:0] key_a, key_b;
    key_a = {$urandom, $urandom};
    key_b = ~key_a;
    model(key_a);
    load_key(key_a, 1'b0);
    key_in = key_b;
    decrypt = 1'b1;
    key_valid = 1'b1;
    collect(70, 16);
    key_valid = 1'b0;
    for (int i = 0; i < obs_k.size(); i++) begin
      n_cmp++;
      if (obs_k[i] !== exp_k[i] || obs_r[i] !== 4'(i)) begin
        n_err++; $display("FAIL ignored_seq[%0d]: key=%h round=%0d, required %h/%0d", i, obs_k[i], obs_r[i], exp_k[i], i);
      end
    end
    n_cmp++;
    if (timed_out || obs_k.size() != 16) begin
      n_err++; $display("FAIL ignored_count: got %0d subkeys, required 16", obs_k.size());
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [63:0] key;
    logic dec;
    for (int t = 0; t < 6; t++) begin
      key = {$urandom, $urandom};
      dec = 1'($urandom_range(1));
      model(key);
      load_key(key, dec);
      collect(t % 2 ? 100 : 60, 16);
      n_cmp++;
      if (timed_out || first_par !== exp_par) begin
        n_err++; $display("FAIL rand_par[%0d]: timed_out=%0b par=%b, required 0/%b", t, timed_out, first_par, exp_par);
      end
      for (int i = 0; i < obs_k.size(); i++) begin
        n_cmp++;
        if (obs_k[i] !== exp_k[dec ? 15 - i : i] || obs_r[i] !== 4'(dec ? 15 - i : i)) begin
          n_err++; $display("FAIL rand_seq[%0d][%0d]: key=%h round=%0d, required %h/%0d", t, i, obs_k[i], obs_r[i],
                            exp_k[dec ? 15 - i : i], dec ? 15 - i : i);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_encrypt;
    test_decrypt;
    test_fixed_order;
    test_stall;
    test_parity;
    test_reset_abort;
    test_key_ignored;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
